// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 read-return path: MIG command codes,
// the collector FSM state type and a width helper.
package ddr2_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_ERR   = 2'd3
    } rd_state_e;

    // Ceiling log2 with a floor of 1, so the result is always a legal
    // vector width even for a value of 1 or 2.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ddr2_rd_collect_fifo.sv
// rd_collect_fifo: synchronous first-word-fall-through FIFO.
// Ports: clk, reset (sync, active-low), push/din, pop, head, count, full, empty.
module rd_collect_fifo
    import ddr2_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 16,
    parameter int CW    = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // A push into a full FIFO is only taken when a pop frees the slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ddr2_rd_collect.sv
// ddr2_rd_collect: snoops MIG READ commands, buffers returned beats and
// presents them as a valid/ready stream; rd_stall throttles read issue.
// Ports: sys_clk, reset (sync, active-low), app_af_* snoop, rd_data_*,
// dout/dout_vd/dout_rdy stream, rd_stall, burst_done, rd_err, err_clr.
// Option: DDR2_RD_BYTESWAP_EN byte-reverses dout at the output mux.
module ddr2_rd_collect
    import ddr2_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_BEATS = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_OUTST   = 4
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  app_af_wren,
    input  logic [2:0]            app_af_cmd,
    input  logic                  app_af_afull,
    input  logic                  rd_data_valid,
    input  logic [DATA_WIDTH-1:0] rd_data_fifo_out,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vd,
    input  logic                  dout_rdy,
    output logic                  rd_stall,
    output logic                  burst_done,
    output logic                  rd_err,
    input  logic                  err_clr
);

    localparam int CW  = clog2(FIFO_DEPTH) + 1;
    localparam int OW  = clog2(MAX_OUTST) + 1;
    localparam int BCW = clog2(BURST_BEATS);
    localparam int SW  = clog2(FIFO_DEPTH) + clog2(MAX_OUTST) + 2;
    localparam int NB  = DATA_WIDTH / 8;

    rd_state_e            state;
    logic [OW-1:0]        outst;
    logic [OW-1:0]        outst_nxt;
    logic [BCW-1:0]       beat_cnt;
    logic [CW-1:0]        fcnt;
    logic [CW-1:0]        cnt_nxt;
    logic [SW-1:0]        stall_sum;
    logic [DATA_WIDTH-1:0] head;
    logic                 f_full;
    logic                 f_empty;
    logic                 rd_issue;
    logic                 outst_max;
    logic                 inc;
    logic                 ovf;
    logic                 beat_ok;
    logic                 beat_unexp;
    logic                 last_beat;
    logic                 pop_acc;
    logic                 push_acc;
    logic                 drop;
    logic                 err_set;

    assign rd_issue  = app_af_wren && !app_af_afull
                       && (app_af_cmd == CMD_READ);
    assign outst_max = (outst == OW'(MAX_OUTST));
    assign inc       = rd_issue && !outst_max;
    assign ovf       = rd_issue && outst_max;

    // Beats with nothing outstanding have no owner and are discarded.
    assign beat_ok    = rd_data_valid && (outst != '0);
    assign beat_unexp = rd_data_valid && (outst == '0);
    assign last_beat  = beat_ok
                        && (beat_cnt == BCW'(BURST_BEATS - 1));

    assign dout_vd  = !f_empty;
    assign pop_acc  = dout_vd && dout_rdy;
    assign push_acc = beat_ok && (!f_full || pop_acc);
    assign drop     = beat_ok && f_full && !pop_acc;
    assign err_set  = ovf || drop || beat_unexp;

    assign outst_nxt = outst + OW'(inc) - OW'(last_beat);
    assign cnt_nxt   = fcnt + CW'(push_acc) - CW'(pop_acc);
    // Space already held plus space promised to bursts in flight.
    assign stall_sum = SW'(cnt_nxt)
                       + SW'(outst_nxt) * SW'(BURST_BEATS);

    rd_collect_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (sys_clk),
        .reset (reset),
        .push  (beat_ok),
        .din   (rd_data_fifo_out),
        .pop   (pop_acc),
        .head  (head),
        .count (fcnt),
        .full  (f_full),
        .empty (f_empty)
    );

    always_comb begin
        dout = '0;
        if (dout_vd) begin
`ifdef DDR2_RD_BYTESWAP_EN
            for (int i = 0; i < NB; i++)
                dout[8*i +: 8] = head[8*(NB-1-i) +: 8];
`else
            dout = head;
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            outst      <= '0;
            beat_cnt   <= '0;
            burst_done <= 1'b0;
            rd_stall   <= 1'b0;
        end else begin
            outst      <= outst_nxt;
            burst_done <= last_beat;
            rd_stall   <= (stall_sum > SW'(FIFO_DEPTH - BURST_BEATS))
                          || (outst_nxt == OW'(MAX_OUTST));
            if (beat_ok)
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            rd_err <= 1'b0;
        end else begin
            if (err_set)
                rd_err <= 1'b1;
            else if (err_clr)
                rd_err <= 1'b0;

            if (err_set) begin
                state <= S_ERR;
            end else begin
                unique case (state)
                    S_IDLE:
                        if (rd_issue) state <= S_WAIT;
                    S_WAIT:
                        if (last_beat)
                            state <= (outst_nxt != '0) ? S_WAIT : S_IDLE;
                        else if (beat_ok)
                            state <= S_BURST;
                    S_BURST:
                        if (last_beat)
                            state <= (outst_nxt != '0) ? S_WAIT : S_IDLE;
                    S_ERR:
                        if (err_clr)
                            state <= (outst_nxt == '0) ? S_IDLE : S_WAIT;
                    default:
                        state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
